bv_gather_sched: RTL
====================

Name: bv_gather_sched

Overview:
- Collects per-field bit vectors from 8 independent field-lookup engines whose latencies differ.
- Buffers each field's vector in its own small FIFO. When all 8 fields hold data for the same packet, it issues them together to the 8-way BV AND stage (bv_in_valid, bv_1..bv_8).
- Provides per-field backpressure, downstream stall, flush, a partial-packet watchdog and error flags.
- Sits between the field lookup engines and the BV AND stage.

Parameters:
- cluster_n, 36, width of each field bit vector.
- DEPTH, 4, entries per field FIFO (power of 2, ≥2).
- TIMEOUT, 64, cycles a partial packet may wait before err_timeout sets.
- CNT_W, 16, width of pkt_cnt.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of FIFOs, FSM and error flags.
- fld_valid  in  8  bit i: field i+1 presents a vector this cycle.
- fld_bv_1..fld_bv_8  in  cluster_n each  field vectors.
- fld_ready  out  8  bit i: FIFO i not full (combinational from registered count).
- out_ready  in  1  downstream can accept an issue this cycle.
- bv_in_valid  out  1  registered issue strobe to the AND stage.
- bv_1..bv_8  out  cluster_n each  registered field vectors of the issued packet.
- pkt_cnt  out  CNT_W  packets issued since reset, wraps.
- busy  out  1  any FIFO non-empty.
- err_ovf  out  1  sticky: a write was attempted to a full FIFO.
- err_timeout  out  1  sticky: a partial packet waited TIMEOUT cycles.

Behaviour:
- Reset (synchronous, active-high): clears all FIFO pointers and counts, FSM→IDLE, timer=0. All outputs 0; bv_1..bv_8=0; fld_ready=8'hFF.
- Write: for each field i, if fld_valid[i] and not full, push at the edge. The word is visible (non-empty) in the next cycle.
- Write when full: the word is dropped, FIFO unchanged, err_ovf←1.
- Issue condition: all 8 FIFOs non-empty and out_ready=1.
- Issue action:
  - Pop all 8 FIFOs at the edge.
  - Register the head words onto bv_1..bv_8 and drive bv_in_valid=1 for exactly one cycle.
  - pkt_cnt+1, wrapping at 2^CNT_W.
- Latency: from the last field write to bv_in_valid is minimum 2 edges (write edge, then issue edge).
- Throughput: one packet per cycle when sustained.
- Simultaneous push and pop on the same FIFO: allowed when not full; count is unchanged and data order is preserved.
  - A full FIFO being popped in the same cycle still reports fld_ready=0. No write is accepted that cycle.
- No issue: bv_in_valid=0; bv_1..bv_8 hold their last values.
- FSM (registered, evaluated on post-update occupancy):
  - IDLE: all FIFOs empty.
  - PARTIAL: ≥1 FIFO non-empty but not all.
  - FULLSET: all non-empty.
- Timer:
  - Increments only in PARTIAL, saturating at TIMEOUT.
  - Reaching TIMEOUT sets err_timeout.
  - Any transition out of PARTIAL clears the timer.
  - FULLSET with out_ready=0 does not count.
- Flush:
  - Same effect as reset on FIFOs, FSM, timer, err_ovf and err_timeout.
  - pkt_cnt and bv_1..bv_8 are retained; bv_in_valid forced 0.
  - Flush has priority over same-cycle writes and issue.
- Reset asserted mid-operation discards all buffered data; no partial issue occurs.
- Pointers are log2(DEPTH) bits, wrap naturally. Count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package bv_pkg holds:
  - FIELD_NUM=8 and the default cluster_n.
  - The FSM state enum (IDLE, PARTIAL, FULLSET).
- One sub-module: bv_field_fifo.
  - Parameters cluster_n, DEPTH.
  - Ports push, pop, din, dout (head, combinational), empty, full, clr.
  - Instantiated 8 times.
- Top holds issue logic, FSM, timer, counters and output registers.

Test Plan:
- Reset then write field vectors 36'h0_0000_0001..36'h0_0000_0080 to fields 1..8 in one cycle, out_ready=1 → bv_in_valid one cycle, 2 edges later; bv_k = written values; pkt_cnt=1.
- Fields 1–7 written at cycle 0, field 8 at cycle 10 → no issue before cycle 11; FSM PARTIAL for 10 cycles; err_timeout stays 0; issue at cycle 12.
- Fields 1–7 written, field 8 never written → err_timeout=1 after 64 cycles in PARTIAL. Flush → err_timeout=0, busy=0, FSM IDLE.
- out_ready=0 while writing 4 packets on all fields → fld_ready=8'h00.
  - 5th write on field 3 → err_ovf=1, word dropped.
  - Release out_ready → 4 back-to-back issues in order, pkt_cnt=4.
- Sustained writes every cycle with out_ready=1 for 20 packets → 20 consecutive bv_in_valid cycles, data order preserved, fld_ready stays 8'hFF.
- Reset asserted while 2 packets are buffered → next cycle busy=0, bv_in_valid=0, pkt_cnt=0, no stale issue after reset release.

Source files
------------

// File: rtl/bv_pkg.sv
// rtl/bv_pkg.sv - shared constants and FSM state type for the BV gather scheduler
package bv_pkg;
  localparam int FIELD_NUM     = 8;
  localparam int CLUSTER_N_DEF = 36;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULLSET = 2'd2
  } state_t;
endpackage

// File: rtl/bv_field_fifo.sv
// rtl/bv_field_fifo.sv - per-field vector FIFO with combinational head and level output
module bv_field_fifo #(
  parameter int cluster_n = 36,
  parameter int DEPTH     = 4
) (
  input  logic                     i_clk,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [cluster_n-1:0]     i_din,
  output logic [cluster_n-1:0]     o_dout,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);

  logic [cluster_n-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 w_push_ok;
  logic                 w_pop_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_level   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  // A full FIFO refuses the write even when it is popped the same cycle.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_clr) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    end
  end
endmodule

// File: rtl/bv_gather_sched.sv
// rtl/bv_gather_sched.sv - aligns 8 field bit vectors per packet and issues them to the BV AND stage
module bv_gather_sched
  import bv_pkg::*;
#(
  parameter int cluster_n = CLUSTER_N_DEF,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_flush,
  input  logic [FIELD_NUM-1:0] i_fld_valid,
  input  logic [cluster_n-1:0] i_fld_bv_1,
  input  logic [cluster_n-1:0] i_fld_bv_2,
  input  logic [cluster_n-1:0] i_fld_bv_3,
  input  logic [cluster_n-1:0] i_fld_bv_4,
  input  logic [cluster_n-1:0] i_fld_bv_5,
  input  logic [cluster_n-1:0] i_fld_bv_6,
  input  logic [cluster_n-1:0] i_fld_bv_7,
  input  logic [cluster_n-1:0] i_fld_bv_8,
  output logic [FIELD_NUM-1:0] o_fld_ready,
  input  logic                 i_out_ready,
  output logic                 o_bv_in_valid,
  output logic [cluster_n-1:0] o_bv_1,
  output logic [cluster_n-1:0] o_bv_2,
  output logic [cluster_n-1:0] o_bv_3,
  output logic [cluster_n-1:0] o_bv_4,
  output logic [cluster_n-1:0] o_bv_5,
  output logic [cluster_n-1:0] o_bv_6,
  output logic [cluster_n-1:0] o_bv_7,
  output logic [cluster_n-1:0] o_bv_8,
  output logic [CNT_W-1:0]     o_pkt_cnt,
  output logic                 o_busy,
  output logic                 o_err_ovf,
  output logic                 o_err_timeout
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [cluster_n-1:0] w_din  [FIELD_NUM];
  logic [cluster_n-1:0] w_head [FIELD_NUM];
  logic [LW-1:0]        w_level [FIELD_NUM];
  logic [LW-1:0]        w_level_nxt [FIELD_NUM];
  logic [FIELD_NUM-1:0] w_empty;
  logic [FIELD_NUM-1:0] w_full;
  logic [FIELD_NUM-1:0] w_push_ok;
  logic [FIELD_NUM-1:0] w_nonempty_nxt;
  logic                 w_clr;
  logic                 w_issue;
  logic                 w_partial_stay;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [TW-1:0]        r_timer;
  logic [cluster_n-1:0] r_bv [FIELD_NUM];

  assign w_din[0] = i_fld_bv_1;
  assign w_din[1] = i_fld_bv_2;
  assign w_din[2] = i_fld_bv_3;
  assign w_din[3] = i_fld_bv_4;
  assign w_din[4] = i_fld_bv_5;
  assign w_din[5] = i_fld_bv_6;
  assign w_din[6] = i_fld_bv_7;
  assign w_din[7] = i_fld_bv_8;

  assign w_clr       = i_reset || i_flush;
  assign w_issue     = (w_empty == '0) && i_out_ready && !w_clr;
  assign w_push_ok   = i_fld_valid & ~w_full;
  assign o_fld_ready = ~w_full;
  assign o_busy      = (w_empty != '1);

  for (genvar g = 0; g < FIELD_NUM; g++) begin : g_fifo
    bv_field_fifo #(.cluster_n(cluster_n), .DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_clr   (w_clr),
      .i_push  (i_fld_valid[g]),
      .i_pop   (w_issue),
      .i_din   (w_din[g]),
      .o_dout  (w_head[g]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g]),
      .o_level (w_level[g])
    );
  end

  // Occupancy after this edge, so the state register tracks the FIFOs without lag.
  always_comb begin
    w_nonempty_nxt = '0;
    for (int i = 0; i < FIELD_NUM; i++) begin
      w_level_nxt[i]    = w_level[i] + LW'(w_push_ok[i]) - LW'(w_issue);
      w_nonempty_nxt[i] = (w_level_nxt[i] != '0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_clr) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_clr)                         w_state_nxt = ST_IDLE;
    else if (w_nonempty_nxt == '1)     w_state_nxt = ST_FULLSET;
    else if (w_nonempty_nxt != '0)     w_state_nxt = ST_PARTIAL;
    else                               w_state_nxt = ST_IDLE;
  end

  assign w_partial_stay = (r_state == ST_PARTIAL) && (w_state_nxt == ST_PARTIAL);

  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_timer       <= '0;
      o_err_timeout <= 1'b0;
    end else if (w_partial_stay) begin
      if (r_timer != TW'(TIMEOUT)) r_timer <= r_timer + TW'(1);
      if (r_timer == TW'(TIMEOUT - 1)) o_err_timeout <= 1'b1;
    end else begin
      r_timer <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_clr)                        o_err_ovf <= 1'b0;
    else if ((i_fld_valid & w_full) != '0) o_err_ovf <= 1'b1;
  end

  // Flush keeps the packet count and the last issued vectors.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_bv_in_valid <= 1'b0;
      o_pkt_cnt     <= '0;
      for (int i = 0; i < FIELD_NUM; i++) r_bv[i] <= '0;
    end else if (i_flush) begin
      o_bv_in_valid <= 1'b0;
    end else begin
      o_bv_in_valid <= w_issue;
      if (w_issue) begin
        o_pkt_cnt <= o_pkt_cnt + CNT_W'(1);
        for (int i = 0; i < FIELD_NUM; i++) r_bv[i] <= w_head[i];
      end
    end
  end

  assign o_bv_1 = r_bv[0];
  assign o_bv_2 = r_bv[1];
  assign o_bv_3 = r_bv[2];
  assign o_bv_4 = r_bv[3];
  assign o_bv_5 = r_bv[4];
  assign o_bv_6 = r_bv[5];
  assign o_bv_7 = r_bv[6];
  assign o_bv_8 = r_bv[7];
endmodule
